nem_ohmux_sel_ctrl: RTL and testbench

Select sequencer and arbiter for the 4-input NEM one-hot inverting mux (nem_ohmux_invd0_4i_8b). It shares the mux among four requesters, or a static configuration override, with round-robin arbitration. It drives the one-hot S0..S3 selects with mandatory break-before-make and mechanical settle windows, because NEM relays switch slowly and must never have two paths closed at once. It sits beside each mux instance in routing/interconnect tiles.

---
 rtl/nem_ohmux_sel_ctrl.sv | 159 +++++++++++++++
 tb/tb_nem_ohmux_sel_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nem_ohmux_sel_ctrl.sv
// Select sequencer/arbiter for the 4-input NEM one-hot inverting mux.
// Round-robin sharing with config override, break-before-make and settle timing.
module nem_ohmux_sel_ctrl #(
    parameter int BREAK_CYC  = 4,
    parameter int SETTLE_CYC = 8,
    parameter int MAX_HOLD   = 0,
    parameter int CNT_W      = 8
) (
    input  logic       CP,
    input  logic       CDN,
    input  logic [3:0] REQ,
    input  logic       CFG_EN,
    input  logic [1:0] CFG_SEL,
    output logic [3:0] S,
    output logic [3:0] GNT,
    output logic       CFG_DONE,
    output logic       BUSY
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MAKE  = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;
    localparam logic [1:0] ST_BREAK = 2'd3;

    localparam int BRK_N = (BREAK_CYC < 1) ? 1 : BREAK_CYC;
    localparam int SET_N = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;

    localparam logic [CNT_W-1:0] BRK_LD   = CNT_W'(BRK_N);
    localparam logic [CNT_W-1:0] SET_LD   = CNT_W'(SET_N);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    function automatic logic [3:0] onehot(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    logic [1:0]       state;
    logic [1:0]       ptr;
    logic [1:0]       win;
    logic             own_cfg;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] hold;

    logic       arb_any;
    logic       arb_cfg;
    logic [1:0] arb_idx;
    logic [1:0] cand;

    // Search downward so the candidate closest above ptr is written last.
    always_comb begin
        arb_any = CFG_EN | (|REQ);
        arb_cfg = CFG_EN;
        arb_idx = CFG_SEL;
        cand    = ptr;
        if (!CFG_EN) begin
            arb_idx = ptr;
            for (int k = 4; k >= 1; k--) begin
                cand = ptr + 2'(k);
                if (REQ[cand]) arb_idx = cand;
            end
        end
    end

    logic own_req;
    logic pre_move;
    logic pre_swap;
    logic others;
    logic hold_exp;

    always_comb begin
        own_req  = own_cfg ? CFG_EN : REQ[win];
        pre_move = (own_cfg || CFG_EN) && (CFG_SEL != win);
        pre_swap = !own_cfg && CFG_EN && (CFG_SEL == win);
        others   = |(REQ & ~onehot(win));
        hold_exp = (MAX_HOLD != 0) && !own_cfg
                   && (hold >= HOLD_MAX) && others;
    end

    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            state    <= ST_IDLE;
            S        <= 4'b0000;
            GNT      <= 4'b0000;
            CFG_DONE <= 1'b0;
            BUSY     <= 1'b0;
            ptr      <= 2'd3;
            win      <= 2'd0;
            own_cfg  <= 1'b0;
            timer    <= '0;
            hold     <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        state   <= ST_MAKE;
                        win     <= arb_idx;
                        own_cfg <= arb_cfg;
                        S       <= onehot(arb_idx);
                        timer   <= SET_LD;
                        BUSY    <= 1'b1;
                    end
                end
                ST_MAKE: begin
                    if (!own_req || pre_move) begin
                        state <= ST_BREAK;
                        S     <= 4'b0000;
                        timer <= BRK_LD;
                    end else begin
                        if (pre_swap) own_cfg <= 1'b1;
                        if (timer == ONE) begin
                            state <= ST_GRANT;
                            hold  <= '0;
                            ptr   <= win;
                            if (pre_swap || own_cfg) CFG_DONE <= 1'b1;
                            else GNT <= onehot(win);
                        end else begin
                            timer <= timer - ONE;
                        end
                    end
                end
                ST_GRANT: begin
                    if (!own_req || pre_move || hold_exp) begin
                        state    <= ST_BREAK;
                        S        <= 4'b0000;
                        GNT      <= 4'b0000;
                        CFG_DONE <= 1'b0;
                        timer    <= BRK_LD;
                    end else begin
                        // Same-index override takes the path without reopening it.
                        if (pre_swap) begin
                            own_cfg  <= 1'b1;
                            GNT      <= 4'b0000;
                            CFG_DONE <= 1'b1;
                        end
                        if (hold != '1) hold <= hold + ONE;
                    end
                end
                ST_BREAK: begin
                    if (timer == ONE) begin
                        if (arb_any) begin
                            state   <= ST_MAKE;
                            win     <= arb_idx;
                            own_cfg <= arb_cfg;
                            S       <= onehot(arb_idx);
                            timer   <= SET_LD;
                        end else begin
                            state <= ST_IDLE;
                            BUSY  <= 1'b0;
                        end
                    end else begin
                        timer <= timer - ONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nem_ohmux_sel_ctrl.sv
// Bench for nem_ohmux_sel_ctrl: timed output-event scoreboard plus invariants.
// Instance a uses default timing with MAX_HOLD=16, instance b uses zero timing.
module tb_nem_ohmux_sel_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] req_a, req_b;
    logic cfg_en_a, cfg_en_b;
    logic [1:0] cfg_sel_a, cfg_sel_b;
    logic [3:0] s_a, gnt_a, s_b, gnt_b;
    logic cd_a, busy_a, cd_b, busy_b;

    always #5 clk = ~clk;

    nem_ohmux_sel_ctrl #(
        .BREAK_CYC(4), .SETTLE_CYC(8), .MAX_HOLD(16), .CNT_W(8)
    ) dut_a (
        .CP(clk), .CDN(rst_n), .REQ(req_a),
        .CFG_EN(cfg_en_a), .CFG_SEL(cfg_sel_a),
        .S(s_a), .GNT(gnt_a), .CFG_DONE(cd_a), .BUSY(busy_a)
    );

    nem_ohmux_sel_ctrl #(
        .BREAK_CYC(0), .SETTLE_CYC(0), .MAX_HOLD(0), .CNT_W(8)
    ) dut_b (
        .CP(clk), .CDN(rst_n), .REQ(req_b),
        .CFG_EN(cfg_en_b), .CFG_SEL(cfg_sel_b),
        .S(s_b), .GNT(gnt_b), .CFG_DONE(cd_b), .BUSY(busy_b)
    );

    typedef struct {
        int         inst;
        int         cyc;
        logic [9:0] v;
    } ev_t;

    ev_t expq[$];
    ev_t e_m;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;
    logic [9:0] prev [2];
    logic [9:0] cur [2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9:0] pk(input logic [3:0] s, input logic [3:0] g,
                                      input logic cd, input logic b);
        return {s, g, cd, b};
    endfunction

    function automatic logic [3:0] oh(input int i);
        return 4'b0001 << i;
    endfunction

    task automatic expect_ev(input int inst, input int at, input logic [3:0] s,
                             input logic [3:0] g, input logic cd, input logic b);
        ev_t e;
        e.inst = inst;
        e.cyc  = at;
        e.v    = pk(s, g, cd, b);
        expq.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic inv_check(input int i, input logic [9:0] c, input logic [9:0] p);
        logic [3:0] s, ps, g;
        logic cd;
        s  = c[9:6];
        g  = c[5:2];
        cd = c[1];
        ps = p[9:6];
        n_checks++;
        if ($countones(s) > 1 || (s != 0 && ps != 0 && s != ps)) begin
            n_fail++;
            $display("FAIL inv_sel inst%0d cyc %0d: S=%b prevS=%b", i, cyc, s, ps);
        end
        n_checks++;
        if (!((g == 0 || (g == s && !cd)) && (!cd || (s != 0 && g == 0)))) begin
            n_fail++;
            $display("FAIL inv_gnt inst%0d cyc %0d: S=%b GNT=%b CD=%b", i, cyc, s, g, cd);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            cur[0] = pk(s_a, gnt_a, cd_a, busy_a);
            cur[1] = pk(s_b, gnt_b, cd_b, busy_b);
            for (int i = 0; i < 2; i++) begin
                inv_check(i, cur[i], prev[i]);
                if (cur[i] !== prev[i]) begin
                    n_checks++;
                    if (expq.size() == 0) begin
                        n_fail++;
                        $display("FAIL ev_unexpected inst%0d cyc %0d: got %b", i, cyc, cur[i]);
                    end else begin
                        e_m = expq.pop_front();
                        if (e_m.inst != i || e_m.cyc != cyc || e_m.v !== cur[i]) begin
                            n_fail++;
                            $display("FAIL ev inst%0d cyc %0d S/G/CD/B %b; want inst%0d cyc %0d %b",
                                     i, cyc, cur[i], e_m.inst, e_m.cyc, e_m.v);
                        end
                    end
                    prev[i] = cur[i];
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick(1);
    endtask

    int c, c1, c2, b;

    initial begin
        rst_n = 1'b1;
        req_a = 4'b0; req_b = 4'b0;
        cfg_en_a = 1'b0; cfg_en_b = 1'b0;
        cfg_sel_a = 2'd0; cfg_sel_b = 2'd0;
        prev[0] = '0; prev[1] = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", {28'd0, s_a} | {gnt_a, 4'd0} | {cd_a, busy_a, 8'd0}, 0);
        chk("reset_b", {28'd0, s_b} | {gnt_b, 4'd0} | {cd_b, busy_b, 8'd0}, 0);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // single request, then release
        tick(10); c = cyc; req_a = 4'b0001;
        expect_ev(0, c + 1, 4'b0001, 4'b0000, 0, 1);
        expect_ev(0, c + 9, 4'b0001, 4'b0001, 0, 1);
        tick(20); c = cyc; req_a = 4'b0000;
        expect_ev(0, c + 1, 4'b0000, 4'b0000, 0, 1);
        expect_ev(0, c + 5, 4'b0000, 4'b0000, 0, 0);
        tick(8);
        chk("idle_busy", busy_a, 0);

        // round robin with forced rotation every 17 grant cycles
        do_reset();
        c = cyc; req_a = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            b = c + 1 + 29 * k;
            expect_ev(0, b, oh(k % 4), 4'b0000, 0, 1);
            expect_ev(0, b + 8, oh(k % 4), oh(k % 4), 0, 1);
            if (k < 4) expect_ev(0, b + 25, 4'b0000, 4'b0000, 0, 1);
        end
        tick(130); c1 = cyc; req_a = 4'b0000;
        expect_ev(0, c1 + 1, 4'b0000, 4'b0000, 0, 1);
        expect_ev(0, c1 + 5, 4'b0000, 4'b0000, 0, 0);
        tick(8);

        // abort during make
        c = cyc; req_a = 4'b0100;
        expect_ev(0, c + 1, 4'b0100, 4'b0000, 0, 1);
        expect_ev(0, c + 4, 4'b0000, 4'b0000, 0, 1);
        expect_ev(0, c + 8, 4'b0000, 4'b0000, 0, 0);
        tick(3); req_a = 4'b0000;
        tick(10);

        // override to a different index
        c = cyc; req_a = 4'b0010;
        expect_ev(0, c + 1, 4'b0010, 4'b0000, 0, 1);
        expect_ev(0, c + 9, 4'b0010, 4'b0010, 0, 1);
        tick(12); c1 = cyc; cfg_en_a = 1'b1; cfg_sel_a = 2'd2;
        expect_ev(0, c1 + 1, 4'b0000, 4'b0000, 0, 1);
        expect_ev(0, c1 + 5, 4'b0100, 4'b0000, 0, 1);
        expect_ev(0, c1 + 13, 4'b0100, 4'b0000, 1, 1);
        tick(16); c2 = cyc; cfg_en_a = 1'b0; req_a = 4'b0000;
        expect_ev(0, c2 + 1, 4'b0000, 4'b0000, 0, 1);
        expect_ev(0, c2 + 5, 4'b0000, 4'b0000, 0, 0);
        tick(8);

        // override to the owned index swaps in place
        c = cyc; req_a = 4'b0010;
        expect_ev(0, c + 1, 4'b0010, 4'b0000, 0, 1);
        expect_ev(0, c + 9, 4'b0010, 4'b0010, 0, 1);
        tick(12); c1 = cyc; cfg_en_a = 1'b1; cfg_sel_a = 2'd1;
        expect_ev(0, c1 + 1, 4'b0010, 4'b0000, 1, 1);
        tick(4); c2 = cyc; cfg_en_a = 1'b0; req_a = 4'b0000;
        expect_ev(0, c2 + 1, 4'b0000, 4'b0000, 0, 1);
        expect_ev(0, c2 + 5, 4'b0000, 4'b0000, 0, 0);
        tick(8);

        // async reset mid-grant, then pointer restart
        c = cyc; req_a = 4'b0100;
        expect_ev(0, c + 1, 4'b0100, 4'b0000, 0, 1);
        expect_ev(0, c + 9, 4'b0100, 4'b0100, 0, 1);
        tick(12);
        #1;
        expect_ev(0, cyc, 4'b0000, 4'b0000, 0, 0);
        rst_n = 1'b0; req_a = 4'b0000;
        #1;
        chk("arst_s", s_a, 0);
        chk("arst_gnt", gnt_a, 0);
        chk("arst_cd", cd_a, 0);
        chk("arst_busy", busy_a, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick(1); c = cyc; req_a = 4'b1001;
        expect_ev(0, c + 1, 4'b0001, 4'b0000, 0, 1);
        expect_ev(0, c + 9, 4'b0001, 4'b0001, 0, 1);
        tick(12); c1 = cyc; req_a = 4'b0000;
        expect_ev(0, c1 + 1, 4'b0000, 4'b0000, 0, 1);
        expect_ev(0, c1 + 5, 4'b0000, 4'b0000, 0, 0);
        tick(8);

        // zero break/settle: one cycle per state
        c = cyc; req_b = 4'b0001;
        expect_ev(1, c + 1, 4'b0001, 4'b0000, 0, 1);
        expect_ev(1, c + 2, 4'b0001, 4'b0001, 0, 1);
        tick(5); c1 = cyc; req_b = 4'b0000;
        expect_ev(1, c1 + 1, 4'b0000, 4'b0000, 0, 1);
        expect_ev(1, c1 + 2, 4'b0000, 4'b0000, 0, 0);
        tick(4);

        // unlimited hold keeps requester 0
        do_reset();
        c = cyc; req_b = 4'b0011;
        expect_ev(1, c + 1, 4'b0001, 4'b0000, 0, 1);
        expect_ev(1, c + 2, 4'b0001, 4'b0001, 0, 1);
        tick(40);
        chk("hold_forever", gnt_b, 4'b0001);
        c1 = cyc; req_b = 4'b0010;
        expect_ev(1, c1 + 1, 4'b0000, 4'b0000, 0, 1);
        expect_ev(1, c1 + 2, 4'b0010, 4'b0000, 0, 1);
        expect_ev(1, c1 + 3, 4'b0010, 4'b0010, 0, 1);
        tick(5); c2 = cyc; req_b = 4'b0000;
        expect_ev(1, c2 + 1, 4'b0000, 4'b0000, 0, 1);
        expect_ev(1, c2 + 2, 4'b0000, 4'b0000, 0, 0);
        tick(4);

        chk("events_left", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
